// File: rtl/object_pool_manager.sv
// object_pool_manager: NUM_OBJ ballistic sprite slots with LFSR spawning and registered pixel hit test; define OBJ_SLICE_EN for blade slicing
module object_pool_manager #(
    parameter int NUM_OBJ   = 4,
    parameter int OBJ_W     = 100,
    parameter int OBJ_H     = 80,
    parameter int ADDR_W    = 18,
    parameter int BASE_ADDR = 18000,
    parameter int KIND_BITS = 3,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int SPAWN_Y   = 375,
    parameter int MIN_DELAY = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        seed,
    input  logic               enable,
    input  logic               move_tick,
    input  logic               acc_tick,
    input  logic [9:0]         col,
    input  logic [9:0]         row,
    input  logic               slice_valid,
    input  logic [9:0]         slice_x,
    input  logic [9:0]         slice_y,
    output logic               pix_hit,
    output logic [2:0]         pix_slot,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic [NUM_OBJ-1:0] active_mask,
    output logic               sliced_pulse,
    output logic [2:0]         sliced_slot
);
    typedef enum logic [1:0] {COOL, SPAWN, FLY} state_t;

    state_t             st [NUM_OBJ], st_n [NUM_OBJ];
    logic [15:0]        cnt [NUM_OBJ], cnt_n [NUM_OBJ];
    logic signed [11:0] x [NUM_OBJ], x_n [NUM_OBJ], y [NUM_OBJ], y_n [NUM_OBJ];
    logic signed [7:0]  vy [NUM_OBJ], vy_n [NUM_OBJ];
    logic [2:0]         vx [NUM_OBJ], vx_n [NUM_OBJ], kind [NUM_OBJ], kind_n [NUM_OBJ];
    logic               dx [NUM_OBJ], dx_n [NUM_OBJ];
    logic [15:0]        lfsr;
    logic [NUM_OBJ-1:0] gnt;
    logic               hit, slice_go;
    logic [2:0]         win, slice_win;
    logic [ADDR_W-1:0]  addr;

    function automatic logic covers(input logic signed [11:0] ox, oy, input logic [9:0] px, py);
        return int'(px) >= int'(ox) && int'(px) < int'(ox) + OBJ_W &&
               int'(py) >= int'(oy) && int'(py) < int'(oy) + OBJ_H;
    endfunction

    // descending scans so the lowest matching index is the one left standing
    always_comb begin
        hit = 1'b0;
        win = 3'd0;
        addr = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--)
            if (st[i] == FLY && covers(x[i], y[i], col, row)) begin
                hit = 1'b1;
                win = 3'(i);
                addr = ADDR_W'(BASE_ADDR + int'(kind[i]) * OBJ_W * OBJ_H +
                               (int'(row) - int'(y[i])) * OBJ_W + int'(col) - int'(x[i]));
            end
    end

    always_comb begin
        gnt = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--)
            if (enable && st[i] == COOL && cnt[i] == 16'd0) gnt = NUM_OBJ'(1) << i;
    end

`ifdef OBJ_SLICE_EN
    always_comb begin
        slice_go = 1'b0;
        slice_win = 3'd0;
        for (int i = NUM_OBJ - 1; i >= 0; i--)
            if (enable && slice_valid && st[i] == FLY && covers(x[i], y[i], slice_x, slice_y)) begin
                slice_go = 1'b1;
                slice_win = 3'(i);
            end
    end
`else
    logic unused_slice;
    assign unused_slice = ^{slice_valid, slice_x, slice_y};
    assign slice_go = 1'b0;
    assign slice_win = 3'd0;
`endif

    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            st_n[i] = st[i];
            cnt_n[i] = cnt[i];
            x_n[i] = x[i];
            y_n[i] = y[i];
            vy_n[i] = vy[i];
            vx_n[i] = vx[i];
            dx_n[i] = dx[i];
            kind_n[i] = kind[i];
            if (enable)
                case (st[i])
                    COOL:
                        if (gnt[i]) st_n[i] = SPAWN;
                        else if (move_tick && cnt[i] != 16'd0) cnt_n[i] = cnt[i] - 16'd1;
                    SPAWN: begin
                        st_n[i] = FLY;
                        x_n[i] = 12'((int'(lfsr[4:0]) * 30) % SCREEN_W);
                        y_n[i] = 12'(SPAWN_Y);
                        vx_n[i] = lfsr[7:5] == 3'd7 ? 3'd0 : lfsr[7:5];
                        dx_n[i] = lfsr[8];
                        vy_n[i] = 8'(-(8 + int'(lfsr[11:9])));
                        kind_n[i] = lfsr[15:13] & 3'((1 << KIND_BITS) - 1);
                    end
                    FLY:
                        if (slice_go && slice_win == 3'(i)) begin
                            st_n[i] = COOL;
                            cnt_n[i] = 16'(MIN_DELAY);
                        end else if ((int'(y[i]) >= SCREEN_H && vy[i] > 8'sd0) ||
                                     int'(x[i]) + OBJ_W <= 0 || int'(x[i]) >= SCREEN_W) begin
                            st_n[i] = COOL;
                            cnt_n[i] = 16'(MIN_DELAY + int'(lfsr[7:0]));
                        end else begin
                            if (acc_tick) vy_n[i] = vy[i] == 8'sd31 ? vy[i] : vy[i] + 8'sd1;
                            if (move_tick) begin
                                x_n[i] = dx[i] ? x[i] - 12'(vx[i]) : x[i] + 12'(vx[i]);
                                y_n[i] = y[i] + 12'(vy[i]);
                            end
                        end
                    default: st_n[i] = COOL;
                endcase
        end
    end

    always_comb for (int i = 0; i < NUM_OBJ; i++) active_mask[i] = st[i] == FLY;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= seed == 16'd0 ? 16'hACE1 : seed;
            for (int i = 0; i < NUM_OBJ; i++) begin
                st[i] <= COOL;
                cnt[i] <= 16'(MIN_DELAY * (i + 1));
                x[i] <= '0;
                y[i] <= '0;
                vy[i] <= '0;
                vx[i] <= '0;
                dx[i] <= 1'b0;
                kind[i] <= '0;
            end
            pix_hit <= 1'b0;
            pix_slot <= 3'd0;
            pix_addr <= '0;
            sliced_pulse <= 1'b0;
            sliced_slot <= 3'd0;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            for (int i = 0; i < NUM_OBJ; i++) begin
                st[i] <= st_n[i];
                cnt[i] <= cnt_n[i];
                x[i] <= x_n[i];
                y[i] <= y_n[i];
                vy[i] <= vy_n[i];
                vx[i] <= vx_n[i];
                dx[i] <= dx_n[i];
                kind[i] <= kind_n[i];
            end
            pix_hit <= hit;
            pix_slot <= win;
            pix_addr <= addr;
            sliced_pulse <= slice_go;
            sliced_slot <= slice_win;
        end
    end
endmodule

// File: tb/tb_object_pool_manager.sv
// tb_object_pool_manager: random stimulus checked every cycle against a behavioural pool model
`timescale 1ns/1ps
module tb_object_pool_manager;
    localparam int N = 4, OW = 100, OH = 80, MD = 8;

    logic clk = 1'b0;
    logic rst, enable, move_tick, acc_tick, slice_valid;
    logic [15:0] seed;
    logic [9:0] col, row, slice_x, slice_y;
    logic pix_hit, sliced_pulse;
    logic [2:0] pix_slot, sliced_slot;
    logic [17:0] pix_addr;
    logic [N-1:0] active_mask;

    object_pool_manager dut (
        .clk(clk), .rst(rst), .seed(seed), .enable(enable), .move_tick(move_tick),
        .acc_tick(acc_tick), .col(col), .row(row), .slice_valid(slice_valid),
        .slice_x(slice_x), .slice_y(slice_y), .pix_hit(pix_hit), .pix_slot(pix_slot),
        .pix_addr(pix_addr), .active_mask(active_mask), .sliced_pulse(sliced_pulse),
        .sliced_slot(sliced_slot)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic chk = 1'b0;

    // model: 0 = cooling, 1 = spawning, 2 = flying
    int m_st [N], m_cnt [N], m_x [N], m_y [N], m_vx [N], m_dx [N], m_vy [N], m_kind [N];
    int m_r, m_sp, m_sl;
    int e_hit, e_slot, e_addr, e_mask, e_sp, e_ss;

    function automatic int wrap12(input int v);
        return ((v + 2048) % 4096 + 4096) % 4096 - 2048;
    endfunction
    function automatic int lfsr_next(input int r);
        return (r >> 1) ^ ((r & 1) != 0 ? 'hB400 : 0);
    endfunction
    function automatic int sx(input int r);
        return ((r & 31) * 30) % 640;
    endfunction
    function automatic int svx(input int r);
        return ((r >> 5) & 7) % 7;
    endfunction
    function automatic int svy(input int r);
        return -(8 + ((r >> 9) & 7));
    endfunction
    function automatic int skind(input int r);
        return (r >> 13) & 7;
    endfunction
    function automatic int covers(input int ox, oy, px, py);
        return (px >= ox && px < ox + OW && py >= oy && py < oy + OH) ? 1 : 0;
    endfunction
    function automatic int addr_of(input int k, ox, oy, px, py);
        return (18000 + k * OW * OH + (py - oy) * OW + (px - ox)) % (1 << 18);
    endfunction
    function automatic int oob(input int ox, oy, vy);
        return ((oy >= 480 && vy > 0) || ox + OW <= 0 || ox >= 640) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_r = seed == 16'd0 ? 'hACE1 : int'(seed);
            for (int i = 0; i < N; i++) begin
                m_st[i] = 0; m_cnt[i] = MD * (i + 1);
                m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_dx[i] = 0; m_vy[i] = 0; m_kind[i] = 0;
            end
            e_hit = 0; e_slot = 0; e_addr = 0; e_sp = 0; e_ss = 0;
        end else begin
            e_hit = 0; e_slot = 0; e_addr = 0;
            for (int i = 0; i < N; i++)
                if (e_hit == 0 && m_st[i] == 2 && covers(m_x[i], m_y[i], col, row) != 0) begin
                    e_hit = 1; e_slot = i;
                    e_addr = addr_of(m_kind[i], m_x[i], m_y[i], col, row);
                end
            m_sl = -1;
`ifdef OBJ_SLICE_EN
            if (enable && slice_valid)
                for (int i = 0; i < N; i++)
                    if (m_sl < 0 && m_st[i] == 2 && covers(m_x[i], m_y[i], slice_x, slice_y) != 0) m_sl = i;
`endif
            e_sp = m_sl >= 0 ? 1 : 0;
            e_ss = m_sl >= 0 ? m_sl : 0;
            m_sp = -1;
            if (enable)
                for (int i = 0; i < N; i++)
                    if (m_sp < 0 && m_st[i] == 0 && m_cnt[i] == 0) m_sp = i;
            if (enable)
                for (int i = 0; i < N; i++)
                    case (m_st[i])
                        0: if (i == m_sp) m_st[i] = 1;
                           else if (move_tick && m_cnt[i] > 0) m_cnt[i]--;
                        1: begin
                            m_st[i] = 2; m_x[i] = sx(m_r); m_y[i] = 375;
                            m_vx[i] = svx(m_r); m_dx[i] = (m_r >> 8) & 1; m_vy[i] = svy(m_r); m_kind[i] = skind(m_r);
                        end
                        default:
                            if (i == m_sl) begin m_st[i] = 0; m_cnt[i] = MD; end
                            else if (oob(m_x[i], m_y[i], m_vy[i]) != 0) begin m_st[i] = 0; m_cnt[i] = MD + m_r % 256; end
                            else begin
                                if (move_tick) begin
                                    m_x[i] = wrap12(m_x[i] + (m_dx[i] != 0 ? -m_vx[i] : m_vx[i]));
                                    m_y[i] = wrap12(m_y[i] + m_vy[i]);
                                end
                                if (acc_tick && m_vy[i] < 31) m_vy[i]++;
                            end
                    endcase
            m_r = lfsr_next(m_r);
        end
        e_mask = 0;
        for (int i = 0; i < N; i++) if (m_st[i] == 2) e_mask |= 1 << i;
    end

    always @(negedge clk) if (chk) begin
        check("pix_hit", int'(pix_hit), e_hit);
        check("pix_slot", int'(pix_slot), e_slot);
        check("pix_addr", int'(pix_addr), e_addr);
        check("active_mask", int'(active_mask), e_mask);
        check("sliced_pulse", int'(sliced_pulse), e_sp);
        check("sliced_slot", int'(sliced_slot), e_ss);
    end

    task automatic pick_point(output logic [9:0] px, output logic [9:0] py);
        int k = int'($urandom_range(0, N - 1));
        int a = m_x[k] + int'($urandom_range(0, 120)) - 10;
        int b = m_y[k] + int'($urandom_range(0, 100)) - 10;
        if ($urandom_range(0, 3) == 0 || a < 0 || a > 1023 || b < 0 || b > 1023) begin
            a = int'($urandom_range(0, 639));
            b = int'($urandom_range(0, 479));
        end
        px = 10'(a);
        py = 10'(b);
    endtask

    initial begin
        int r;
        rst = 1'b1; seed = 16'd0; enable = 1'b0; move_tick = 1'b0; acc_tick = 1'b0;
        col = '0; row = '0; slice_valid = 1'b0; slice_x = '0; slice_y = '0;
        @(posedge clk);
        #1 chk = 1'b1;
        @(negedge clk);
        check("reset_mask", int'(active_mask), 0);
        check("reset_hit", int'(pix_hit), 0);
        check("reset_pulse", int'(sliced_pulse), 0);
        check("model_lfsr_step", lfsr_next('hACE1), 'hE270);
        r = 2 | (3 << 5) | (2 << 13);
        check("model_spawn_x", sx(r), 60);
        check("model_spawn_vx", svx(r), 3);
        check("model_spawn_vy", svy(r), -8);
        check("model_spawn_kind", skind(r), 2);
        check("model_vx_mod7", svx(7 << 5), 0);
        check("model_move_y", wrap12(375 + svy(r)), 367);
        check("model_move2_y", wrap12(367 + svy(r) + 1), 360);
        check("model_addr", addr_of(2, 100, 200, 150, 210), 35050);
        check("model_cover_in", covers(100, 200, 150, 210), 1);
        check("model_cover_edge", covers(100, 200, 200, 210), 0);
        check("model_oob_fall", oob(0, 480, 1), 1);
        check("model_oob_rising", oob(0, 480, 0), 0);
        check("model_oob_left", oob(-100, 0, 0), 1);
        check("model_oob_left_in", oob(-99, 0, 0), 0);
        check("model_oob_right", oob(640, 0, 0), 1);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            move_tick = 1'b1;
            @(negedge clk);
            move_tick = 1'b0;
            repeat (2) @(negedge clk);
            if (t == 7) check("mask_before_first_spawn", int'(active_mask), 0);
            if (t == 8) check("slot0_first_fly", int'(active_mask), 1);
            if (t == 16) check("slot1_flying", int'(active_mask[1]), 1);
        end
        for (int c = 0; c < 24000; c++) begin
            enable = (c >= 12000 && c < 12300) ? 1'b0 : ($urandom_range(0, 19) != 0);
            move_tick = $urandom_range(0, 1) == 1;
            acc_tick = $urandom_range(0, 2) == 0;
            pick_point(col, row);
            pick_point(slice_x, slice_y);
            slice_valid = $urandom_range(0, 15) == 0;
            rst = c == 18000 || c == 18001;
            if (c == 18000) seed = 16'($urandom);
            @(negedge clk);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
